scc_fetch_queue: RTL and testbench

//   Instruction prefetch queue between the scc core and instruction_and_data.

---
 rtl/scc_fetch_queue.sv | 103 ++++++++++
 tb/tb_scc_fetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scc_fetch_queue.sv
// scc_fetch_queue: instruction prefetch queue sitting between the scc core and
// the instruction memory. It issues sequential fetches and absorbs the one-cycle
// memory read latency. It buffers up to DEPTH {word, pc} entries and hands them
// to the core over a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at a new address.
module scc_fetch_queue #(
  parameter int unsigned          DEPTH    = 4,
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          PC_INC   = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        halt_f,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        imem_en,
  output logic [ADDR_W-1:0]           imem_a,
  input  logic [DATA_W-1:0]           imem_v,
  output logic                        inst_valid,
  output logic [DATA_W-1:0]           inst_v,
  output logic [ADDR_W-1:0]           inst_pc,
  input  logic                        inst_ready,
  output logic [$clog2(DEPTH+1)-1:0]  q_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag_pc;
  logic              pend;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  logic [DATA_W-1:0] word_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [CW:0]       reserved;
  logic              push;
  logic              pop;

  // Issue, push and pop decisions; the in-flight request counts against free space
  always_comb begin
    reserved   = {1'b0, count} + (CW + 1)'(pend);
    imem_en    = clk_en & ~halt_f & ~redirect & ~rst & (reserved < (CW + 1)'(DEPTH));
    inst_valid = (count != '0);
    push       = pend & ~redirect;
    pop        = clk_en & inst_valid & inst_ready & ~redirect;
  end

  assign imem_a  = fetch_pc;
  assign inst_v  = word_mem[rd_ptr];
  assign inst_pc = pc_mem[rd_ptr];
  assign q_count = count;

  // Fetch PC, pending flag, pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= RESET_PC;
      pend     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      pend     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pend <= imem_en;
      if (imem_en) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
        tag_pc   <= fetch_pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; the returning word is paired with the PC it was fetched from
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      word_mem[wr_ptr] <= imem_v;
      pc_mem[wr_ptr]   <= tag_pc;
    end
  end

endmodule

// File: tb/tb_scc_fetch_queue.sv
// tb_scc_fetch_queue: directed, table-driven bench for scc_fetch_queue with a
// one-cycle-latency instruction memory model.
module tb_scc_fetch_queue;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        halt_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_a;
  logic [31:0] imem_v;
  logic        inst_valid;
  logic [31:0] inst_v;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  q_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ce;
    logic        halt;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_en;
    logic [31:0] e_a;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  scc_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .halt_f      (halt_f),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_a      (imem_a),
    .imem_v      (imem_v),
    .inst_valid  (inst_valid),
    .inst_v      (inst_v),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .q_count     (q_count)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory word encodes its address so each fetched word is traceable to its PC
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0000;
  endfunction

  // Instruction memory model: data appears the cycle after the read enable
  always @(posedge clk) begin
    if (imem_en) imem_v <= mem_word(imem_a);
  end

  task automatic add_vec(input logic ce, input logic halt, input logic redir,
                         input logic [31:0] rpc, input logic ready,
                         input logic e_en, input logic [31:0] e_a,
                         input logic e_valid, input logic [31:0] e_pc,
                         input logic [2:0] e_count);
    vec_t v;
    v = '{ce, halt, redir, rpc, ready, e_en, e_a, e_valid, e_pc, e_count};
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic ce, input logic halt,
                                input logic redir, input logic [31:0] rpc,
                                input logic ready);
    @(negedge clk);
    rst         = r;
    clk_en      = ce;
    halt_f      = halt;
    redirect    = redir;
    redirect_pc = rpc;
    inst_ready  = ready;
    #1;
  endtask

  initial begin
    int cycles;

    rst = 1'b1; clk_en = 1'b0; halt_f = 1'b0; redirect = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0; imem_v = '0;

    //      ce h  rd rpc            rdy  en a              v  pc             cnt
    // streaming with ready=1
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h4,         0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h8,         1, 32'h0,         3'd1);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'hC,         1, 32'h4,         3'd1);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h10,        1, 32'h8,         3'd1);
    // ready=0: fill to DEPTH, issue stops
    add_vec(1, 0, 0, 32'h0,         0,   1, 32'h14,        1, 32'hC,         3'd1);
    add_vec(1, 0, 0, 32'h0,         0,   1, 32'h18,        1, 32'hC,         3'd2);
    add_vec(1, 0, 0, 32'h0,         0,   0, 32'h1C,        1, 32'hC,         3'd3);
    add_vec(1, 0, 0, 32'h0,         0,   0, 32'h1C,        1, 32'hC,         3'd4);
    add_vec(1, 0, 0, 32'h0,         0,   0, 32'h1C,        1, 32'hC,         3'd4);
    // release ready: pops and refill
    add_vec(1, 0, 0, 32'h0,         1,   0, 32'h1C,        1, 32'hC,         3'd4);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h1C,        1, 32'h10,        3'd3);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h20,        1, 32'h14,        3'd2);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h24,        1, 32'h18,        3'd2);
    // 3 queued + 1 pending, then redirect to 0x100 (pop in that cycle ignored)
    add_vec(1, 0, 0, 32'h0,         0,   1, 32'h28,        1, 32'h1C,        3'd2);
    add_vec(1, 0, 1, 32'h100,       1,   0, 32'h2C,        1, 32'h1C,        3'd3);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h104,       0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h108,       1, 32'h100,       3'd1);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h10C,       1, 32'h104,       3'd1);
    // halt mid-stream: pending word still captured, queue drains
    add_vec(1, 1, 0, 32'h0,         1,   0, 32'h110,       1, 32'h108,       3'd1);
    add_vec(1, 1, 0, 32'h0,         1,   0, 32'h110,       1, 32'h10C,       3'd1);
    add_vec(1, 1, 0, 32'h0,         1,   0, 32'h110,       0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h110,       0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h114,       0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h118,       1, 32'h110,       3'd1);
    // clk_en=0 for 3 cycles with one pending request
    add_vec(0, 0, 0, 32'h0,         1,   0, 32'h11C,       1, 32'h114,       3'd1);
    add_vec(0, 0, 0, 32'h0,         1,   0, 32'h11C,       1, 32'h114,       3'd2);
    add_vec(0, 0, 0, 32'h0,         1,   0, 32'h11C,       1, 32'h114,       3'd2);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h11C,       1, 32'h114,       3'd2);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h120,       1, 32'h118,       3'd1);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h124,       1, 32'h11C,       3'd1);
    // redirect near the top of the address space: PC wraps to 0
    add_vec(1, 0, 1, 32'hFFFFFFFC,  1,   0, 32'h128,       1, 32'h120,       3'd1);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'hFFFFFFFC,  0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         3'd0);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h4,         1, 32'hFFFFFFFC,  3'd1);
    add_vec(1, 0, 0, 32'h0,         1,   1, 32'h8,         1, 32'h0,         3'd1);

    // Reset state
    apply_stimulus(1, 0, 0, 0, 32'h0, 0);
    apply_stimulus(1, 1, 0, 0, 32'h0, 1);
    check_output("reset imem_en", 32'(imem_en), 32'd0);
    check_output("reset imem_a", imem_a, 32'h0);
    check_output("reset inst_valid", 32'(inst_valid), 32'd0);
    check_output("reset q_count", 32'(q_count), 32'd0);

    // Table-driven main sequence
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(0, vecs[i].ce, vecs[i].halt, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      check_output($sformatf("c%0d imem_en", i), 32'(imem_en), 32'(vecs[i].e_en));
      check_output($sformatf("c%0d imem_a", i), imem_a, vecs[i].e_a);
      check_output($sformatf("c%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
      check_output($sformatf("c%0d q_count", i), 32'(q_count), 32'(vecs[i].e_count));
      if (vecs[i].e_valid) begin
        check_output($sformatf("c%0d inst_pc", i), inst_pc, vecs[i].e_pc);
        check_output($sformatf("c%0d inst_v", i), inst_v, mem_word(vecs[i].e_pc));
      end
    end

    // Reset applied while a fetch is pending: the response must be dropped
    apply_stimulus(1, 1, 0, 0, 32'h0, 0);
    check_output("rst imem_en gated", 32'(imem_en), 32'd0);
    apply_stimulus(1, 1, 0, 0, 32'h0, 0);
    check_output("rst2 imem_en", 32'(imem_en), 32'd0);
    check_output("rst2 imem_a", imem_a, 32'h0);
    check_output("rst2 inst_valid", 32'(inst_valid), 32'd0);
    check_output("rst2 q_count", 32'(q_count), 32'd0);
    apply_stimulus(1, 1, 0, 0, 32'h0, 0);
    check_output("rst3 q_count", 32'(q_count), 32'd0);

    // Release reset: first word shows up two cycles later (bounded wait)
    apply_stimulus(0, 1, 0, 0, 32'h0, 1);
    check_output("rel imem_en", 32'(imem_en), 32'd1);
    check_output("rel imem_a", imem_a, 32'h0);
    cycles = 0;
    while (!inst_valid && cycles < 10) begin
      apply_stimulus(0, 1, 0, 0, 32'h0, 1);
      cycles++;
    end
    check_output("rel valid latency", 32'(cycles), 32'd2);
    check_output("rel first inst_pc", inst_pc, 32'h0);
    check_output("rel first inst_v", inst_v, mem_word(32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
